// File: rtl/hash_table_pkg.sv
// ---------------------------------------------------------------------------
// hash_table_pkg
// Definitions shared by the hash-table blocks:
//   - rescode_e      : 3-bit result code returned by the upsert engine
//   - upsert_state_e : state encoding of the upsert FSM
//   - data-word packing helpers for {key, value, next_ptr, next_ptr_val}
//     stored MSB to LSB, so next_ptr_val sits in bit 0
//   - chain_len_w    : width of the chain-length counter
// ---------------------------------------------------------------------------
package hash_table_pkg;

  typedef enum logic [2:0] {
    SUCCESS          = 3'd0,
    SUCCESS_SAME_KEY = 3'd1,
    FIND_SAME_KEY    = 3'd2,
    TABLE_IS_FULL    = 3'd3,
    CHAIN_TOO_LONG   = 3'd4
  } rescode_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    MATCH_WR = 3'd2,
    HEAD_WR  = 3'd3,
    DATA_WR  = 3'd4,
    LINK_WR  = 3'd5,
    RESP     = 3'd6
  } upsert_state_e;

  // Bit position of next_ptr_val inside a data word.
  localparam int PTR_VAL_BIT = 0;

  // LSB of the next_ptr field.
  function automatic int ptr_lsb();
    return 1;
  endfunction

  // LSB of the value field.
  function automatic int value_lsb(input int a_w);
    return a_w + 1;
  endfunction

  // LSB of the key field.
  function automatic int key_lsb(input int value_w, input int a_w);
    return value_w + a_w + 1;
  endfunction

  // Total width of one data word.
  function automatic int data_w(input int key_w, input int value_w, input int a_w);
    return key_w + value_w + a_w + 1;
  endfunction

  // Chain counter must hold MAX_CHAIN+1 distinct values; never narrower than 8.
  function automatic int chain_len_w(input int max_chain);
    int w;
    w = $clog2(max_chain + 2);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/rd_data_val_helper.sv
// ---------------------------------------------------------------------------
// rd_data_val_helper
// LATENCY-deep shift register that turns the RAM read strobe into a
// read-data-valid flag aligned with the RAM output.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset
//   rd_en_i       : read strobe issued to the RAM
//   rd_val_o      : high exactly LATENCY cycles after rd_en_i
// ---------------------------------------------------------------------------
module rd_data_val_helper #(
  parameter int LATENCY = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rd_en_i,
  output logic rd_val_o
);

  logic [LATENCY-1:0] shift_q, shift_d;

  always_comb begin
    shift_d    = shift_q << 1;
    shift_d[0] = rd_en_i;
  end

  // Clearing the pipeline on reset drops any read still in flight, so an
  // abandoned task can never see its data arrive afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) shift_q <= '0;
    else       shift_q <= shift_d;
  end

  assign rd_val_o = shift_q[LATENCY-1];

endmodule

// File: rtl/data_table_upsert.sv
// ---------------------------------------------------------------------------
// data_table_upsert
// Inserts or updates one {key, value} pair in a chained hash table.
// A task names a bucket and its chain head; the engine walks the chain in the
// data RAM, then either rewrites a matching entry, appends a new entry to the
// tail, or creates the chain by writing the head table, and reports a result.
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   task_*                       : valid/ready task input (bucket, key, value,
//                                  chain head pointer and its valid flag)
//   rd_en_o/rd_addr_o/rd_data_i  : data-RAM read port, RAM_LATENCY cycles
//   wr_en_o/wr_addr_o/wr_data_o  : data-RAM write port
//   empty_addr_*                 : free-address source, ack consumes one
//   head_wr_*                    : head-table write port (pointer always valid)
//   result_*                     : valid/ready result (code, address, reads)
// ---------------------------------------------------------------------------
module data_table_upsert
  import hash_table_pkg::*;
#(
  parameter int KEY_W       = 32,
  parameter int VALUE_W     = 32,
  parameter int A_WIDTH     = 10,
  parameter int BUCKET_W    = 10,
  parameter int RAM_LATENCY = 2,
  parameter int OVERWRITE   = 1,
  parameter int MAX_CHAIN   = 0,
  localparam int DATA_W     = data_w(KEY_W, VALUE_W, A_WIDTH),
  localparam int CL_W       = chain_len_w(MAX_CHAIN)
) (
  input  logic                clk_i,
  input  logic                rst_i,

  input  logic                task_valid_i,
  output logic                task_ready_o,
  input  logic [BUCKET_W-1:0] task_bucket_i,
  input  logic [KEY_W-1:0]    task_key_i,
  input  logic [VALUE_W-1:0]  task_value_i,
  input  logic [A_WIDTH-1:0]  task_head_ptr_i,
  input  logic                task_head_ptr_val_i,

  output logic                rd_en_o,
  output logic [A_WIDTH-1:0]  rd_addr_o,
  input  logic [DATA_W-1:0]   rd_data_i,

  output logic                wr_en_o,
  output logic [A_WIDTH-1:0]  wr_addr_o,
  output logic [DATA_W-1:0]   wr_data_o,

  input  logic [A_WIDTH-1:0]  empty_addr_i,
  input  logic                empty_addr_val_i,
  output logic                empty_addr_rd_ack_o,

  output logic                head_wr_en_o,
  output logic [BUCKET_W-1:0] head_wr_addr_o,
  output logic [A_WIDTH-1:0]  head_wr_ptr_o,

  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [2:0]          result_rescode_o,
  output logic [A_WIDTH-1:0]  result_addr_o,
  output logic [CL_W-1:0]     result_chain_len_o
);

  localparam int PTR_LSB = ptr_lsb();
  localparam int VAL_LSB = value_lsb(A_WIDTH);
  localparam int KEY_LSB = key_lsb(VALUE_W, A_WIDTH);
  localparam logic [CL_W-1:0] CHAIN_LIMIT = CL_W'(MAX_CHAIN);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  upsert_state_e         state_q,    state_d;
  logic [BUCKET_W-1:0]   bucket_q,   bucket_d;
  logic [KEY_W-1:0]      key_q,      key_d;
  logic [VALUE_W-1:0]    value_q,    value_d;
  logic [A_WIDTH-1:0]    rd_addr_q,  rd_addr_d;   // address of the current chain entry
  logic                  rd_issue_q, rd_issue_d;  // strobe the read on this RD_WAIT cycle
  logic [DATA_W-1:0]     word_q,     word_d;      // last word read from the chain
  logic [CL_W-1:0]       count_q,    count_d;
  logic                  tail_q,     tail_d;      // DATA_WR reached from the chain tail
  rescode_e              rescode_q,  rescode_d;
  logic [A_WIDTH-1:0]    res_addr_q, res_addr_d;

  logic                  rd_val;
  logic [KEY_W-1:0]      rd_key;
  logic [A_WIDTH-1:0]    rd_next_ptr;
  logic                  rd_next_val;
  logic                  key_hit;
  logic                  chain_full;
  logic [CL_W-1:0]       count_inc;
  logic [DATA_W-1:0]     match_word;
  logic [DATA_W-1:0]     new_word;
  logic [DATA_W-1:0]     link_word;

  rd_data_val_helper #(
    .LATENCY (RAM_LATENCY)
  ) u_rd_val (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_en_i  (rd_en_o),
    .rd_val_o (rd_val)
  );

  // -------------------------------------------------------------------------
  // Word decode / encode
  // -------------------------------------------------------------------------
  assign rd_key      = rd_data_i[KEY_LSB +: KEY_W];
  assign rd_next_ptr = rd_data_i[PTR_LSB +: A_WIDTH];
  assign rd_next_val = rd_data_i[PTR_VAL_BIT];
  assign key_hit     = (rd_key == key_q);
  assign chain_full  = (MAX_CHAIN != 0) && (count_q == CHAIN_LIMIT);
  assign count_inc   = (count_q == '1) ? count_q : count_q + 1'b1;

  always_comb begin
    match_word                       = word_q;
    match_word[VAL_LSB +: VALUE_W]   = value_q;

    new_word                         = '0;
    new_word[KEY_LSB +: KEY_W]       = key_q;
    new_word[VAL_LSB +: VALUE_W]     = value_q;

    link_word                        = word_q;
    link_word[PTR_LSB +: A_WIDTH]    = empty_addr_i;
    link_word[PTR_VAL_BIT]           = 1'b1;
  end

  // -------------------------------------------------------------------------
  // Next state and outputs
  // -------------------------------------------------------------------------
  // NOTE: every variable gets a default first, so no path through the case
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d             = state_q;
    bucket_d            = bucket_q;
    key_d               = key_q;
    value_d             = value_q;
    rd_addr_d           = rd_addr_q;
    rd_issue_d          = rd_issue_q;
    word_d              = word_q;
    count_d             = count_q;
    tail_d              = tail_q;
    rescode_d           = rescode_q;
    res_addr_d          = res_addr_q;

    task_ready_o        = 1'b0;
    rd_en_o             = 1'b0;
    wr_en_o             = 1'b0;
    wr_addr_o           = '0;
    wr_data_o           = '0;
    empty_addr_rd_ack_o = 1'b0;
    head_wr_en_o        = 1'b0;
    result_valid_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        task_ready_o = 1'b1;
        if (task_valid_i) begin
          bucket_d  = task_bucket_i;
          key_d     = task_key_i;
          value_d   = task_value_i;
          rd_addr_d = task_head_ptr_i;
          count_d   = '0;
          tail_d    = 1'b0;
          if (task_head_ptr_val_i) begin
            rd_issue_d = 1'b1;
            state_d    = RD_WAIT;
          end else if (!empty_addr_val_i) begin
            rescode_d  = TABLE_IS_FULL;
            res_addr_d = '0;
            state_d    = RESP;
          end else begin
            state_d    = HEAD_WR;
          end
        end
      end

      RD_WAIT: begin
        if (rd_issue_q) begin
          rd_en_o    = 1'b1;
          rd_issue_d = 1'b0;
          count_d    = count_inc;
        end else if (rd_val) begin
          word_d = rd_data_i;
          if (key_hit) begin
            res_addr_d = rd_addr_q;
            if (OVERWRITE != 0) begin
              rescode_d = SUCCESS_SAME_KEY;
              state_d   = MATCH_WR;
            end else begin
              rescode_d = FIND_SAME_KEY;
              state_d   = RESP;
            end
          end else if (rd_next_val) begin
            if (chain_full) begin
              rescode_d  = CHAIN_TOO_LONG;
              res_addr_d = '0;
              state_d    = RESP;
            end else begin
              // Follow the chain: read strobe goes out on the next cycle.
              rd_addr_d  = rd_next_ptr;
              rd_issue_d = 1'b1;
            end
          end else if (!empty_addr_val_i) begin
            rescode_d  = TABLE_IS_FULL;
            res_addr_d = '0;
            state_d    = RESP;
          end else begin
            tail_d  = 1'b1;
            state_d = DATA_WR;
          end
        end
      end

      MATCH_WR: begin
        wr_en_o   = 1'b1;
        wr_addr_o = rd_addr_q;
        wr_data_o = match_word;
        state_d   = RESP;
      end

      HEAD_WR: begin
        head_wr_en_o = 1'b1;
        state_d      = DATA_WR;
      end

      DATA_WR: begin
        wr_en_o   = 1'b1;
        wr_addr_o = empty_addr_i;
        wr_data_o = new_word;
        if (tail_q) begin
          state_d = LINK_WR;
        end else begin
          // Head path: this is the last write, so the free address is consumed here.
          empty_addr_rd_ack_o = 1'b1;
          rescode_d           = SUCCESS;
          res_addr_d          = empty_addr_i;
          state_d             = RESP;
        end
      end

      LINK_WR: begin
        wr_en_o             = 1'b1;
        wr_addr_o           = rd_addr_q;
        wr_data_o           = link_word;
        empty_addr_rd_ack_o = 1'b1;
        rescode_d           = SUCCESS;
        res_addr_d          = empty_addr_i;
        state_d             = RESP;
      end

      RESP: begin
        result_valid_o = 1'b1;
        if (result_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rd_addr_o          = rd_addr_q;
  assign head_wr_addr_o     = bucket_q;
  assign head_wr_ptr_o      = empty_addr_i;
  assign result_rescode_o   = rescode_q;
  assign result_addr_o      = res_addr_q;
  assign result_chain_len_o = count_q;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: non-blocking assignments, so every register samples the values from
  // before the clock edge regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      bucket_q   <= '0;
      key_q      <= '0;
      value_q    <= '0;
      rd_addr_q  <= '0;
      rd_issue_q <= 1'b0;
      word_q     <= '0;
      count_q    <= '0;
      tail_q     <= 1'b0;
      rescode_q  <= SUCCESS;
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      bucket_q   <= bucket_d;
      key_q      <= key_d;
      value_q    <= value_d;
      rd_addr_q  <= rd_addr_d;
      rd_issue_q <= rd_issue_d;
      word_q     <= word_d;
      count_q    <= count_d;
      tail_q     <= tail_d;
      rescode_q  <= rescode_d;
      res_addr_q <= res_addr_d;
    end
  end

endmodule

// File: tb/tb_data_table_upsert.sv
// ---------------------------------------------------------------------------
// tb_data_table_upsert
// Directed, table-driven bench for data_table_upsert (defaults, MAX_CHAIN=2).
// A behavioural RAM with a two-cycle read pipeline serves the chain reads;
// a negedge monitor logs every strobe for later comparison.
// ---------------------------------------------------------------------------
module tb_data_table_upsert;
  import hash_table_pkg::*;

  localparam int KW = 32;
  localparam int VW = 32;
  localparam int AW = 10;
  localparam int BW = 10;
  localparam int DW = KW + VW + AW + 1;
  localparam int CW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          task_valid_i;
  logic          task_ready_o;
  logic [BW-1:0] task_bucket_i;
  logic [KW-1:0] task_key_i;
  logic [VW-1:0] task_value_i;
  logic [AW-1:0] task_head_ptr_i;
  logic          task_head_ptr_val_i;
  logic          rd_en_o;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_data_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic [AW-1:0] empty_addr_i;
  logic          empty_addr_val_i;
  logic          empty_addr_rd_ack_o;
  logic          head_wr_en_o;
  logic [BW-1:0] head_wr_addr_o;
  logic [AW-1:0] head_wr_ptr_o;
  logic          result_valid_o;
  logic          result_ready_i;
  logic [2:0]    result_rescode_o;
  logic [AW-1:0] result_addr_o;
  logic [CW-1:0] result_chain_len_o;

  data_table_upsert #(
    .KEY_W(KW), .VALUE_W(VW), .A_WIDTH(AW), .BUCKET_W(BW),
    .RAM_LATENCY(2), .OVERWRITE(1), .MAX_CHAIN(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .task_valid_i(task_valid_i), .task_ready_o(task_ready_o),
    .task_bucket_i(task_bucket_i), .task_key_i(task_key_i),
    .task_value_i(task_value_i), .task_head_ptr_i(task_head_ptr_i),
    .task_head_ptr_val_i(task_head_ptr_val_i),
    .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .empty_addr_i(empty_addr_i), .empty_addr_val_i(empty_addr_val_i),
    .empty_addr_rd_ack_o(empty_addr_rd_ack_o),
    .head_wr_en_o(head_wr_en_o), .head_wr_addr_o(head_wr_addr_o),
    .head_wr_ptr_o(head_wr_ptr_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_rescode_o(result_rescode_o), .result_addr_o(result_addr_o),
    .result_chain_len_o(result_chain_len_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- RAM model: two-cycle read latency ----------------
  logic [DW-1:0] mem [1024];
  logic [DW-1:0] pipe0, pipe1;

  always @(posedge clk_i) begin
    if (rd_en_o) pipe0 <= mem[rd_addr_o];
    pipe1 <= pipe0;
  end
  assign rd_data_i = pipe1;

  // ---------------- strobe monitor (cumulative logs) ----------------
  int            n_wr_tot = 0, n_ack_tot = 0, n_head_tot = 0, n_rd_tot = 0;
  int            n_illegal = 0;
  logic [AW-1:0] wr_a [64];
  logic [DW-1:0] wr_d [64];
  logic [AW-1:0] rd_a [64];
  logic [BW-1:0] head_a_last;
  logic [AW-1:0] head_p_last;

  always @(negedge clk_i) begin
    if (wr_en_o) begin
      wr_a[n_wr_tot % 64] = wr_addr_o;
      wr_d[n_wr_tot % 64] = wr_data_o;
      n_wr_tot++;
    end
    if (rd_en_o) begin
      rd_a[n_rd_tot % 64] = rd_addr_o;
      n_rd_tot++;
    end
    if (empty_addr_rd_ack_o) n_ack_tot++;
    if (head_wr_en_o) begin
      head_a_last = head_wr_addr_o;
      head_p_last = head_wr_ptr_o;
      n_head_tot++;
    end
    if ((task_ready_o || result_valid_o) &&
        (wr_en_o || rd_en_o || empty_addr_rd_ack_o || head_wr_en_o))
      n_illegal++;
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pk(input logic [KW-1:0] k, input logic [VW-1:0] v,
                                       input logic [AW-1:0] p, input logic pv);
    return {k, v, p, pv};
  endfunction

  typedef struct {
    logic [BW-1:0] bucket;
    logic [KW-1:0] key;
    logic [VW-1:0] value;
    logic [AW-1:0] head;
    logic          head_val;
    logic [AW-1:0] empty;
    logic          empty_val;
    int            hold;     // cycles to keep result_ready_i low once valid
    logic [2:0]    code;
    logic [AW-1:0] addr;
    logic [CW-1:0] chain;
    int            lat;      // cycles from accept to result_valid_o
    int            n_wr;
    int            n_ack;
    int            n_head;
    int            n_rd;
    logic [AW-1:0] w0a;
    logic [DW-1:0] w0d;
    logic [AW-1:0] w1a;
    logic [DW-1:0] w1d;
  } vec_t;

  function automatic vec_t mk(
    input logic [BW-1:0] bucket, input logic [KW-1:0] key, input logic [VW-1:0] value,
    input logic [AW-1:0] head, input logic head_val,
    input logic [AW-1:0] empty, input logic empty_val, input int hold,
    input logic [2:0] code, input logic [AW-1:0] addr, input logic [CW-1:0] chain,
    input int lat, input int n_wr, input int n_ack, input int n_head, input int n_rd,
    input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
    input logic [AW-1:0] w1a, input logic [DW-1:0] w1d);
    vec_t v;
    v.bucket = bucket; v.key = key; v.value = value; v.head = head; v.head_val = head_val;
    v.empty = empty; v.empty_val = empty_val; v.hold = hold;
    v.code = code; v.addr = addr; v.chain = chain; v.lat = lat;
    v.n_wr = n_wr; v.n_ack = n_ack; v.n_head = n_head; v.n_rd = n_rd;
    v.w0a = w0a; v.w0d = w0d; v.w1a = w1a; v.w1d = w1d;
    return v;
  endfunction

  task automatic drive_task(input vec_t v);
    task_bucket_i       = v.bucket;
    task_key_i          = v.key;
    task_value_i        = v.value;
    task_head_ptr_i     = v.head;
    task_head_ptr_val_i = v.head_val;
    empty_addr_i        = v.empty;
    empty_addr_val_i    = v.empty_val;
    task_valid_i        = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   b_wr, b_ack, b_head, b_rd, lat, w;
    bit   got;
    logic first_rd;
    string p;
    p = $sformatf("v%0d_", idx);

    @(negedge clk_i);
    drive_task(v);
    w = 0;
    while (!task_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    check({p, "ready"}, task_ready_o, 1'b1);
    b_wr = n_wr_tot; b_ack = n_ack_tot; b_head = n_head_tot; b_rd = n_rd_tot;
    @(posedge clk_i);
    #1 task_valid_i = 1'b0;

    lat = 0; got = 1'b0; first_rd = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk_i);
      lat++;
      if (lat == 1) first_rd = rd_en_o;
      if (result_valid_o) got = 1'b1;
    end
    check({p, "result_valid"}, got, 1'b1);
    check({p, "latency"}, lat, v.lat);
    check({p, "first_cycle_rd_en"}, first_rd, v.head_val);
    check({p, "rescode"}, result_rescode_o, v.code);
    check({p, "addr"}, result_addr_o, v.addr);
    check({p, "chain_len"}, result_chain_len_o, v.chain);

    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk_i);
      check({p, $sformatf("hold%0d_valid", h)}, result_valid_o, 1'b1);
      check({p, $sformatf("hold%0d_fields", h)},
            {result_rescode_o, result_addr_o, result_chain_len_o},
            {v.code, v.addr, v.chain});
    end

    result_ready_i = 1'b1;
    @(posedge clk_i);
    #1 result_ready_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check({p, "idle_after_resp"}, {task_ready_o, result_valid_o}, 2'b10);

    check({p, "n_writes"}, n_wr_tot - b_wr, v.n_wr);
    check({p, "n_acks"}, n_ack_tot - b_ack, v.n_ack);
    check({p, "n_head_wr"}, n_head_tot - b_head, v.n_head);
    check({p, "n_reads"}, n_rd_tot - b_rd, v.n_rd);
    if (v.n_rd > 0 && n_rd_tot > b_rd)
      check({p, "first_rd_addr"}, rd_a[b_rd % 64], v.head);
    if (v.n_wr > 0 && n_wr_tot > b_wr)
      check({p, "wr0"}, {wr_a[b_wr % 64], wr_d[b_wr % 64]}, {v.w0a, v.w0d});
    if (v.n_wr > 1 && n_wr_tot > b_wr + 1)
      check({p, "wr1"}, {wr_a[(b_wr + 1) % 64], wr_d[(b_wr + 1) % 64]}, {v.w1a, v.w1d});
    if (v.n_head > 0 && n_head_tot > b_head)
      check({p, "head_wr"}, {head_a_last, head_p_last}, {v.bucket, v.empty});
  endtask

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   b_wr, b_ack, b_head, b_rd, w;
    bit   saw_valid;
    vec_t rv;

    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[3]  = pk(32'hA3, 32'h3333, 10'd7,  1'b1);
    mem[7]  = pk(32'hB7, 32'h7777, 10'd0,  1'b0);
    mem[20] = pk(32'h20, 32'h2020, 10'd21, 1'b1);
    mem[21] = pk(32'h21, 32'h2121, 10'd22, 1'b1);
    mem[22] = pk(32'h22, 32'h2222, 10'd23, 1'b1);
    mem[23] = pk(32'h23, 32'h2323, 10'd0,  1'b0);

    //            bucket key     value         head  hv  empty ev hold code              addr ch lat wr ak hd rd  w0a  w0d                                   w1a  w1d
    vecs[0] = mk(4, 32'h11, 32'hAAAA0011, 0,  0, 5,  1, 0, SUCCESS,          5, 0, 3, 1, 1, 1, 0, 5, pk(32'h11, 32'hAAAA0011, 0, 0), 0, '0);
    vecs[1] = mk(6, 32'h12, 32'h12,       0,  0, 5,  0, 0, TABLE_IS_FULL,    0, 0, 1, 0, 0, 0, 0, 0, '0,                             0, '0);
    vecs[2] = mk(8, 32'hB7, 32'h5555,     3,  1, 9,  1, 0, SUCCESS_SAME_KEY, 7, 2, 8, 1, 0, 0, 2, 7, pk(32'hB7, 32'h5555, 0, 0),     0, '0);
    vecs[3] = mk(8, 32'hA3, 32'h6666,     3,  1, 9,  1, 0, SUCCESS_SAME_KEY, 3, 1, 5, 1, 0, 0, 1, 3, pk(32'hA3, 32'h6666, 7, 1),     0, '0);
    vecs[4] = mk(9, 32'h99, 32'h9999,     7,  1, 9,  1, 0, SUCCESS,          9, 1, 6, 2, 1, 0, 1, 9, pk(32'h99, 32'h9999, 0, 0),     7, pk(32'hB7, 32'h7777, 9, 1));
    vecs[5] = mk(9, 32'h99, 32'h9999,     7,  1, 9,  0, 0, TABLE_IS_FULL,    0, 1, 4, 0, 0, 0, 1, 0, '0,                             0, '0);
    vecs[6] = mk(2, 32'h99, 32'h9999,     20, 1, 9,  1, 5, CHAIN_TOO_LONG,   0, 2, 7, 0, 0, 0, 2, 0, '0,                             0, '0);
    vecs[7] = mk(3, 32'h44, 32'h4444,     0,  0, 12, 1, 2, SUCCESS,         12, 0, 3, 1, 1, 1, 0, 12, pk(32'h44, 32'h4444, 0, 0),   0, '0);

    rst_i = 1'b1; task_valid_i = 1'b0; result_ready_i = 1'b0;
    task_bucket_i = '0; task_key_i = '0; task_value_i = '0;
    task_head_ptr_i = '0; task_head_ptr_val_i = 1'b0;
    empty_addr_i = '0; empty_addr_val_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_ready", task_ready_o, 1'b1);
    check("reset_strobes", {rd_en_o, wr_en_o, empty_addr_rd_ack_o, head_wr_en_o}, 4'b0);
    check("reset_result", {result_valid_o, result_rescode_o, result_addr_o, result_chain_len_o}, '0);
    rst_i = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while a chain read is outstanding: the task must vanish.
    rv = vecs[6];
    @(negedge clk_i);
    drive_task(rv);
    w = 0;
    while (!task_ready_o && w < 20) begin
      @(negedge clk_i);
      w++;
    end
    @(posedge clk_i);
    #1 task_valid_i = 1'b0;
    @(negedge clk_i);
    check("rst_mid_rd_en_before", rd_en_o, 1'b1);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    b_wr = n_wr_tot; b_ack = n_ack_tot; b_head = n_head_tot; b_rd = n_rd_tot;
    @(negedge clk_i);
    check("rst_mid_ready", task_ready_o, 1'b1);
    check("rst_mid_result", {result_valid_o, result_rescode_o, result_chain_len_o}, '0);
    rst_i = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (result_valid_o) saw_valid = 1'b1;
    end
    check("rst_mid_no_result", saw_valid, 1'b0);
    check("rst_mid_no_strobes",
          {n_wr_tot - b_wr, n_ack_tot - b_ack, n_head_tot - b_head, n_rd_tot - b_rd}, '0);

    check("no_strobe_in_idle_or_resp", n_illegal, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/data_table_upsert.md
DATA_TABLE_UPSERT -- requirements
Module: data_table_upsert
Interface
REQ-001 SHALL have parameter KEY_W, default 32, key width.
REQ-002 SHALL have parameter VALUE_W, default 32, value width.
REQ-003 SHALL have parameter A_WIDTH, default 10, data-RAM address width.
REQ-004 SHALL have parameter BUCKET_W, default 10, head-table address width.
REQ-005 SHALL have parameter RAM_LATENCY, default 2 (>=1), cycles from rd_en_o to valid rd_data_i.
REQ-006 SHALL have parameter OVERWRITE, default 1; 1 = rewrite value on key match, 0 = report the match only.
REQ-007 SHALL have parameter MAX_CHAIN, default 0; maximum chain reads per task, 0 = unlimited.
REQ-008 SHALL have port clk_i  in  1  clock.
REQ-009 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-010 SHALL have port task_valid_i  in  1  task offered.
REQ-011 SHALL have port task_ready_o  out  1  task accepted when valid and ready both high.
REQ-012 SHALL have port task_bucket_i  in  BUCKET_W  bucket index.
REQ-013 SHALL have port task_key_i  in  KEY_W  key.
REQ-014 SHALL have port task_value_i  in  VALUE_W  value.
REQ-015 SHALL have port task_head_ptr_i  in  A_WIDTH  chain head address.
REQ-016 SHALL have port task_head_ptr_val_i  in  1  head pointer valid.
REQ-017 SHALL have port rd_en_o  out  1  RAM read strobe.
REQ-018 SHALL have port rd_addr_o  out  A_WIDTH  read address.
REQ-019 SHALL have port rd_data_i  in  DATA_W  read word {key,value,next_ptr,next_ptr_val}; DATA_W = KEY_W+VALUE_W+A_WIDTH+1.
REQ-020 SHALL have port wr_en_o  out  1  RAM write strobe.
REQ-021 SHALL have port wr_addr_o  out  A_WIDTH  write address.
REQ-022 SHALL have port wr_data_o  out  DATA_W  write word, same layout as rd_data_i.
REQ-023 SHALL have port empty_addr_i  in  A_WIDTH  next free address.
REQ-024 SHALL have port empty_addr_val_i  in  1  free address available.
REQ-025 SHALL have port empty_addr_rd_ack_o  out  1  one-cycle pulse consuming the free address.
REQ-026 SHALL have port head_wr_en_o  out  1  head-table write strobe; written pointer is always valid.
REQ-027 SHALL have port head_wr_addr_o  out  BUCKET_W  head-table address (captured bucket).
REQ-028 SHALL have port head_wr_ptr_o  out  A_WIDTH  new head pointer (empty_addr_i).
REQ-029 SHALL have port result_valid_o  out  1  result available.
REQ-030 SHALL have port result_ready_i  in  1  result consumed.
REQ-031 SHALL have port result_rescode_o  out  3  result code, encoded per the shared package.
REQ-032 SHALL have port result_addr_o  out  A_WIDTH  written or matched address.
REQ-033 SHALL have port result_chain_len_o  out  CL_W  number of RAM reads performed; CL_W = $clog2(MAX_CHAIN+2), minimum 8.
Function
REQ-034 SHALL implement FSM IDLE, RD_WAIT, MATCH_WR, HEAD_WR, DATA_WR, LINK_WR, RESP; task_ready_o=1 only in IDLE; accepted task fields are captured on accept.
REQ-035 SHALL, on accept with task_head_ptr_val_i=0: go to RESP with TABLE_IS_FULL if empty_addr_val_i=0, else HEAD_WR (head_wr_en_o one cycle) then DATA_WR then RESP with SUCCESS; result_valid_o rises exactly 3 cycles after accept.
REQ-036 SHALL, on accept with task_head_ptr_val_i=1: pulse rd_en_o one cycle at task_head_ptr_i on the first RD_WAIT cycle, take data exactly RAM_LATENCY cycles later, and increment the chain counter (saturating) per read.
REQ-037 SHALL, on read data: on key match with OVERWRITE=1, write the read word with the value replaced at the read address (MATCH_WR) and report SUCCESS_SAME_KEY; with OVERWRITE=0, report FIND_SAME_KEY with no write; no match with next_ptr_val=1 and count=MAX_CHAIN (nonzero) reports CHAIN_TOO_LONG, otherwise the next read is issued at next_ptr on the following cycle; at tail, report TABLE_IS_FULL if empty_addr_val_i=0, else DATA_WR then LINK_WR.
REQ-038 SHALL write {key,value,0,0} at empty_addr_i in DATA_WR, and write the saved tail word with next_ptr=empty_addr_i, next_ptr_val=1 at the tail address in LINK_WR; empty_addr_rd_ack_o pulses in the last write cycle of the task (DATA_WR on the head path, LINK_WR on the tail path).
REQ-039 SHALL hold result_valid_o and all result fields stable in RESP until result_ready_i=1, then return to IDLE; no write, ack or read strobe occurs in RESP or IDLE, and each strobe lasts exactly one cycle.
Reset
REQ-040 SHALL, with rst_i high, force state IDLE, counters and read-valid pipeline 0, all strobes, result_valid_o and result fields 0, task_ready_o 1; a reset mid-task abandons the task with no later write, ack or result.
Structure
REQ-041 SHALL take rescode enum (SUCCESS, SUCCESS_SAME_KEY, FIND_SAME_KEY, TABLE_IS_FULL, CHAIN_TOO_LONG) and the data-word packing from the shared hash_table package.
REQ-042 SHALL use one sub-module, rd_data_val_helper, a RAM_LATENCY-deep shift register generating read-data valid.
Verification
REQ-043 SHALL cover: empty bucket, key 0x11, free address 5 -> head_wr bucket->5, write {0x11,v,0,0}@5, ack, SUCCESS, result_valid 3 cycles after accept.
REQ-044 SHALL cover: chain 3->7, key in @7, OVERWRITE=1, RAM_LATENCY=2 -> two reads, write at 7 with new value, SUCCESS_SAME_KEY, addr 7, chain_len 2.
REQ-045 SHALL cover: tail 7, no match, free address 9 -> write @9, link @7 next_ptr=9, ack once, SUCCESS; with empty_addr_val_i=0 -> TABLE_IS_FULL, no writes.
REQ-046 SHALL cover: MAX_CHAIN=2, chain of 4 with no match -> CHAIN_TOO_LONG after 2 reads; result_ready_i held low 5 cycles -> fields stable; rst_i mid-RD_WAIT -> no strobes afterwards.
